// File: rtl/vga_console_pkg.sv
// Shared geometry, character codes and state encoding for the text console controller.
package vga_console_pkg;
    localparam logic [6:0]  COLS     = 7'd80;
    localparam logic [5:0]  ROWS     = 6'd60;
    localparam logic [12:0] VRAM_END = 13'd4799;
    localparam logic [6:0]  LAST_COL = 7'd79;
    localparam logic [5:0]  LAST_ROW = 6'd59;

    localparam logic [7:0]  CH_SPACE = 8'h20;
    localparam logic [7:0]  CH_TILDE = 8'h7E;
    localparam logic [7:0]  CH_LF    = 8'h0A;
    localparam logic [7:0]  CH_CR    = 8'h0D;
    localparam logic [7:0]  CH_BS    = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ALL,
        CLR_ROW
    } state_t;
endpackage

// File: rtl/vga_console_ctrl_if.sv
// Host-side byte stream and clear-request bundle of the console controller.
interface vga_console_ctrl_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       cls;

    modport master (output char_valid, char_data, cls, input char_ready);
    modport slave  (input char_valid, char_data, cls, output char_ready);
endinterface

// File: rtl/console_addr_gen.sv
// Logical (y, x) plus scroll offset to physical VRAM address: ((y+line) mod 60)*80 + x.
module console_addr_gen
    import vga_console_pkg::*;
(
    input  logic [5:0]  y,
    input  logic [6:0]  x,
    input  logic [5:0]  line,
    output logic [12:0] addr
);
    logic [6:0] row_sum;
    logic [6:0] prow;

    // Both operands are below ROWS, so one conditional subtract covers the wrap.
    assign row_sum = {1'b0, y} + {1'b0, line};
    assign prow    = (row_sum >= {1'b0, ROWS}) ? row_sum - {1'b0, ROWS} : row_sum;
    assign addr    = {prow, 6'b0} + {2'b0, prow, 4'b0} + {6'b0, x};
endmodule

// File: rtl/vga_console_ctrl.sv
// Character-stream console: byte decode, cursor tracking, hardware scroll and VRAM clearing.
module vga_console_ctrl
    import vga_console_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    vga_console_ctrl_if.slave host,
    output logic [12:0]       vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    output logic [5:0]        line,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);
    state_t      state_q, state_d;
    logic [12:0] clr_addr_q, clr_addr_d;
    logic [12:0] clr_left_q, clr_left_d;
    logic        pend_q, pend_d;
    logic [12:0] vram_addr_q, vram_addr_d;
    logic        vram_we_q, vram_we_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;
    logic [5:0]  line_q, line_d;
    logic [6:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic        char_ready_q, char_ready_d;
    logic        busy_q, busy_d;

    logic [12:0] cur_addr, row_base;
    logic        clear_req, in_idle, start_all, accept, is_print, do_nl, scroll;

    assign clear_req = pend_q | host.cls;
    assign in_idle   = (state_q == IDLE);
    assign start_all = in_idle & clear_req;
    // A clear request in the same cycle as a byte wins; the byte stays offered.
    assign accept    = in_idle & char_ready_q & host.char_valid & ~clear_req;
    assign is_print  = (host.char_data >= CH_SPACE) && (host.char_data <= CH_TILDE);
    assign do_nl     = accept && ((host.char_data == CH_LF) || (is_print && cx_q == LAST_COL));
    assign scroll    = do_nl && (cy_q == LAST_ROW);

    console_addr_gen u_cur_addr (.y(cy_q), .x(cx_q), .line(line_q), .addr(cur_addr));
    console_addr_gen u_row_base (.y(6'd0), .x(7'd0), .line(line_q), .addr(row_base));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= CLR_ALL;
            clr_addr_q   <= '0;
            clr_left_q   <= VRAM_END + 13'd1;
            pend_q       <= 1'b0;
            vram_addr_q  <= '0;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= '0;
            line_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clr_left_q   <= clr_left_d;
            pend_q       <= pend_d;
            vram_addr_q  <= vram_addr_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            line_q       <= line_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_left_d = clr_left_q;
        pend_d     = clear_req;
        case (state_q)
            IDLE: begin
                if (start_all) begin
                    state_d    = CLR_ALL;
                    clr_addr_d = '0;
                    clr_left_d = VRAM_END + 13'd1;
                    pend_d     = 1'b0;
                end else if (scroll) begin
                    state_d = CLR_ROW;
                    // A wrapping printable owns this cycle's write; otherwise the first cell goes now.
                    if (is_print) begin
                        clr_addr_d = row_base;
                        clr_left_d = {6'd0, COLS};
                    end else begin
                        clr_addr_d = row_base + 13'd1;
                        clr_left_d = {6'd0, LAST_COL};
                    end
                end
            end
            default: begin
                clr_addr_d = clr_addr_q + 13'd1;
                clr_left_d = clr_left_q - 13'd1;
                if (clr_left_q == 13'd1) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        vram_we_d    = 1'b0;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        line_d       = line_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        if (!in_idle) begin
            vram_we_d    = 1'b1;
            vram_addr_d  = clr_addr_q;
            vram_wdata_d = CH_SPACE;
        end else if (start_all) begin
            line_d = '0;
            cx_d   = '0;
            cy_d   = '0;
        end else if (accept) begin
            if (is_print) begin
                vram_we_d    = 1'b1;
                vram_addr_d  = cur_addr;
                vram_wdata_d = host.char_data;
                cx_d         = (cx_q == LAST_COL) ? 7'd0 : cx_q + 7'd1;
            end else begin
                case (host.char_data)
                    CH_LF, CH_CR: cx_d = '0;
                    CH_BS:        if (cx_q != 7'd0) cx_d = cx_q - 7'd1;
                    default:      ;
                endcase
            end
            if (do_nl) begin
                if (cy_q != LAST_ROW) begin
                    cy_d = cy_q + 6'd1;
                end else begin
                    line_d = (line_q == LAST_ROW) ? 6'd0 : line_q + 6'd1;
                    if (!is_print) begin
                        vram_we_d    = 1'b1;
                        vram_addr_d  = row_base;
                        vram_wdata_d = CH_SPACE;
                    end
                end
            end
        end
        char_ready_d = in_idle && (state_d == IDLE) && !pend_d;
        busy_d       = !in_idle || (state_d != IDLE);
    end

    assign host.char_ready = char_ready_q;
    assign vram_addr       = vram_addr_q;
    assign vram_we         = vram_we_q;
    assign vram_wdata      = vram_wdata_q;
    assign line            = line_q;
    assign cursor_x        = cx_q;
    assign cursor_y        = cy_q;
    assign busy            = busy_q;
endmodule
